// File: rtl/led7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : led7seg_scan
// Description : Time-multiplexed 4-digit scan driver for one 7-segment
//               decoder. It holds a 16-bit value as four hex nibbles and
//               presents one nibble per slot on d. It drives active-low
//               anode selects on sa, with a blanking guard at the start of
//               every slot. Loads go into a shadow register and reach the
//               display only at a frame boundary, so a frame never mixes
//               old and new digits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DIV        - clock cycles per digit slot (>= BLANK_CYC+2)
//               BLANK_CYC  - all-anodes-off cycles at slot start (>= 1)
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               ld         - load strobe, sampled every clk edge
//               din[15:0]  - value to display, din[3:0] = rightmost digit
//               d[3:0]     - nibble for the current slot (decoder input)
//               sa[3:0]    - anode selects, active-low, at most one low
//               pend       - a loaded value waits for the next frame boundary
// Build macro : LED7SEG_LZB_EN - when defined, leading-zero blanking is
//               enabled: slot k>0 stays dark while disp[15:4k] is zero.
// ============================================================================
module led7seg_scan #(
    parameter int DIV       = 12500,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] din,
    output logic [3:0]  d,
    output logic [3:0]  sa,
    output logic        pend
);

    localparam int            c_cnt_w   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK_CYC);

    // Scan state and data registers
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_k;
    logic [15:0]        r_disp;
    logic [15:0]        r_shd;

    // Next-state values for the scan position and display data
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [1:0]         w_k_nxt;
    logic [15:0]        w_disp_nxt;
    logic               w_slot_end;
    logic               w_frame_end;

    // Next values for the registered outputs
    logic [3:0]         w_d_nxt;
    logic [3:0]         w_sa_lit;
    logic [3:0]         w_sa_nxt;
    logic               w_lz_blank;

    // ------------------------------------------------------------------
    // Scan position: the prescaler wraps every DIV cycles, and each wrap
    // advances the slot index. The last cycle of slot 3 is the frame
    // boundary.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_end  = (r_cnt == c_cnt_max);
        w_frame_end = w_slot_end && (r_k == 2'd3);
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_k_nxt     = w_slot_end ? r_k + 2'd1 : r_k;
    end

    // ------------------------------------------------------------------
    // Display data: the shadow value moves over only on the boundary edge.
    // Because w_disp_nxt feeds the d/sa lookahead below, the first slot of
    // the new frame already shows the new value.
    // ------------------------------------------------------------------
    always_comb begin
        w_disp_nxt = (w_frame_end && pend) ? r_shd : r_disp;
    end

    // ------------------------------------------------------------------
    // Output lookahead: d and sa are registered, so they are computed from
    // the position the scan moves to on this edge. d is reloaded only when
    // a slot is entered. That is always a blanked cycle, so the nibble
    // never changes while a digit is lit.
    // ------------------------------------------------------------------
    always_comb begin
        w_d_nxt = d;
        if (w_slot_end) begin
            w_d_nxt = w_disp_nxt[{w_k_nxt, 2'b00} +: 4];
        end
    end

    always_comb begin
        w_sa_lit = 4'b1111;
        case (w_k_nxt)
            2'd0:    w_sa_lit = 4'b1110;
            2'd1:    w_sa_lit = 4'b1101;
            2'd2:    w_sa_lit = 4'b1011;
            default: w_sa_lit = 4'b0111;
        endcase
    end

`ifdef LED7SEG_LZB_EN
    // A digit is a leading zero when it and every digit to its left are
    // zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
    always_comb begin
        w_lz_blank = 1'b0;
        case (w_k_nxt)
            2'd1:    w_lz_blank = (w_disp_nxt[15:4]  == 12'h000);
            2'd2:    w_lz_blank = (w_disp_nxt[15:8]  == 8'h00);
            2'd3:    w_lz_blank = (w_disp_nxt[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    always_comb begin
        w_lz_blank = 1'b0;
    end
`endif

    always_comb begin
        w_sa_nxt = w_sa_lit;
        if ((w_cnt_nxt < c_blank) || w_lz_blank) begin
            w_sa_nxt = 4'b1111;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_k    <= 2'd0;
            r_disp <= 16'h0000;
            r_shd  <= 16'h0000;
            pend   <= 1'b0;
            d      <= 4'h0;
            sa     <= 4'b1111;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_k    <= w_k_nxt;
            r_disp <= w_disp_nxt;
            d      <= w_d_nxt;
            sa     <= w_sa_nxt;

            // A load always wins the shadow register and keeps pend set.
            // On a boundary it coincides with, the older shadow value has
            // already gone to the display through w_disp_nxt.
            if (ld) begin
                r_shd <= din;
                pend  <= 1'b1;
            end else if (w_frame_end) begin
                pend  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_led7seg_scan
// Description : Randomized bench for led7seg_scan with DIV=8, BLANK_CYC=2.
//               A reference model tracks elapsed cycles since reset and
//               derives slot and position arithmetically. It checks d, sa
//               and pend after every clock edge. The bench follows the
//               LED7SEG_LZB_EN macro in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led7seg_scan;

    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [15:0] din;
    logic [3:0]  d;
    logic [3:0]  sa;
    logic        pend;

    led7seg_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .din  (din),
        .d    (d),
        .sa   (sa),
        .pend (pend)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycles since reset release, displayed value,
    // waiting value and pending flag.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_shd;
    logic        m_pend;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int m_slot();
        return (m_t / DIV) % 4;
    endfunction

    function automatic int m_pos();
        return m_t % DIV;
    endfunction

    function automatic logic [3:0] exp_d();
        logic [15:0] v;
        v = m_disp >> (4 * m_slot());
        return v[3:0];
    endfunction

    function automatic logic [3:0] exp_sa();
        logic [3:0] one;
        one = 4'b0001;
        if (m_pos() < BLANK_CYC) return 4'b1111;
`ifdef LED7SEG_LZB_EN
        if (m_slot() > 0 && (m_disp >> (4 * m_slot())) == 16'h0) return 4'b1111;
`endif
        return ~(one << m_slot());
    endfunction

    task automatic check_outputs();
        check_val("d",    {12'h0, d},     {12'h0, exp_d()});
        check_val("sa",   {12'h0, sa},    {12'h0, exp_sa()});
        check_val("pend", {15'h0, pend},  {15'h0, m_pend});
    endtask

    // One clock cycle with the given load inputs, then check the outputs.
    task automatic step(input logic l, input logic [15:0] v);
        logic boundary;
        ld  = l;
        din = v;
        @(posedge clk);
        boundary = (m_pos() == DIV - 1) && (m_slot() == 3);
        if (boundary && m_pend) m_disp = m_shd;
        if (l) begin
            m_shd  = v;
            m_pend = 1'b1;
        end else if (boundary) begin
            m_pend = 1'b0;
        end
        m_t++;
        #1;
        check_outputs();
        ld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    // Idle until the model sits at the given slot and position. A position
    // is always reached within one frame, so a timeout counts as a failure.
    task automatic advance_to(input int s, input int p);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i <= 4 * DIV; i++) begin
            if (m_slot() == s && m_pos() == p) begin
                reached = 1'b1;
                break;
            end
            step(1'b0, 16'h0);
        end
        check_val("advance_reach", {15'h0, reached}, 16'h1);
    endtask

    // Asynchronous reset pulse placed away from the clock edge. The
    // outputs must clear before any clock edge follows.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_sa",   {12'h0, sa},   16'h000F);
        check_val("rst_d",    {12'h0, d},    16'h0000);
        check_val("rst_pend", {15'h0, pend}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_t    = 0;
        m_disp = 16'h0;
        m_shd  = 16'h0;
        m_pend = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        ld  = 1'b0;
        din = 16'h0;
        do_reset();

        // Idle scan after reset
        idle(40);

        // Single load in the middle of slot 1
        advance_to(1, 4);
        step(1'b1, 16'h1234);
        idle(2 * 4 * DIV);

        // Two loads before a boundary: the last one wins
        advance_to(0, 3);
        step(1'b1, 16'hAAAA);
        idle(5);
        step(1'b1, 16'h5678);
        idle(2 * 4 * DIV);

        // Load exactly on the frame-boundary cycle while another is pending
        advance_to(1, 0);
        step(1'b1, 16'h1111);
        advance_to(3, DIV - 1);
        step(1'b1, 16'h00C0);
        check_val("bnd_pend", {15'h0, pend}, 16'h0001);
        idle(3 * 4 * DIV);

        // Reset in slot 2 with a value shown and another pending
        step(1'b1, 16'hBEEF);
        idle(2 * 4 * DIV);
        step(1'b1, 16'h4321);
        advance_to(2, 5);
        do_reset();
        idle(4 * DIV + 4);

        // Values with leading zeros
        step(1'b1, 16'h0030);
        idle(2 * 4 * DIV);
        step(1'b1, 16'h0000);
        idle(2 * 4 * DIV);
        step(1'b1, 16'h0F00);
        idle(2 * 4 * DIV);

        // Randomized loads with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 2) == 0)
                    step(1'b1, 16'($urandom_range(0, 255)));
                else
                    step(1'b1, 16'($urandom));
            end else begin
                step(1'b0, 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led7seg_scan.md
# led7seg_scan

Time-multiplexed 4-digit scan driver that sits directly upstream of the single-digit 7-segment decoder. It holds a 16-bit value as four hex nibbles and presents one nibble at a time on `D`, which feeds the decoder's 4-bit input. It drives the active-low anode selects `SA` so that each digit is lit in turn. Loads are double-buffered and take effect only at a frame boundary, so the display never shows a mix of old and new digits.

## Interface
- `DIV`, default 12500: clock cycles per digit slot; must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off (ghosting guard); must be ≥ 1.
- `CLK` input 1: the single clock; all state updates on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `LD` input 1: load strobe, sampled on every `CLK` edge.
- `DIN` input 16: value to display; `DIN[3:0]` is digit 0 (rightmost), `DIN[15:12]` is digit 3.
- `D` output 4: nibble for the current slot, to the decoder input.
- `SA` output 4: anode selects, active-low; bit k low means digit k is lit; at most one bit is low at any time.
- `PEND` output 1: high while a loaded value is waiting for the next frame boundary.

## Operation
- State:
  - prescaler `cnt`: 0..`DIV`-1
  - slot index `k`: 0..3
  - display register `disp[15:0]`
  - shadow register `shd[15:0]`
  - `PEND`
- All outputs are registered.
- Reset, asynchronous, takes effect immediately: `cnt`=0, `k`=0, `disp`=0, `shd`=0, `PEND`=0, `D`=4'h0, `SA`=4'b1111.
- Prescaler:
  - `cnt` increments every cycle.
  - At `cnt`==`DIV`-1 it wraps to 0 and `k` advances 0→1→2→3→0.
  - A frame boundary is the cycle with `cnt`==`DIV`-1 and `k`==3.
- Slot outputs:
  - `D` = `disp[4k+3:4k]` for the slot being entered, updated on the first cycle of the slot.
  - `SA` = 4'b1111 while `cnt` < `BLANK_CYC`.
  - Otherwise `SA` = ~(4'b0001 << k).
- Load handling:
  - `LD`=1 writes `DIN` into `shd` and sets `PEND`=1 on the next edge.
  - `LD` while `PEND`=1 overwrites `shd`; the last load wins.
- Frame-boundary transfer:
  - At a frame boundary with `PEND`=1: `disp` ← `shd` and `PEND` ← 0.
  - The first slot of the new frame (k=0) shows the new value.
- Simultaneous `LD` and frame boundary:
  - The old `shd` is transferred to `disp`.
  - `DIN` is written to `shd`.
  - `PEND` stays 1, and the new value is transferred at the following frame boundary.
- `LD` at a frame boundary with `PEND`=0: no transfer this boundary; `PEND` becomes 1.
- Reset mid-frame: the display blanks immediately, the pending load is discarded, and scanning restarts at slot 0, `cnt`=0.

## Timing
- Slot length is `DIV` cycles; frame length is 4·`DIV` cycles; each digit is lit for `DIV`-`BLANK_CYC` cycles per frame.
- After reset release, slot 0 starts with `cnt`=0; `SA` first goes low (4'b1110) after `BLANK_CYC` cycles.
- `LD` at edge t: `PEND`=1 after edge t; `disp` updates at the next frame-boundary edge.
- Load-to-visible latency is at most 4·`DIV`+1 cycles, plus `BLANK_CYC` until the digit is lit.
- `D` changes only on cycles where `SA`=4'b1111.

## Configuration
- Macro: `LED7SEG_LZB_EN` (leading-zero blanking).
- Defined:
  - In slot k>0, `SA` stays 4'b1111 for the whole slot if `disp[15:4k]`==0.
  - Digit 0 is always shown, so the value 0 displays a single "0".
  - `D` behaves as in the base operation.
- Not defined: all four digits are always shown, including leading zeros.
- Scan timing, `D`, and `PEND` are identical in both builds.

## Test plan
All scenarios use `DIV`=8 and `BLANK_CYC`=2.
- Reset then idle 40 cycles:
  - `D`=0 throughout.
  - `SA` sequence per slot is 1111×2, then 1110×6, 1101×6, 1011×6, 0111×6, repeating.
  - `PEND`=0 throughout.
- `LD` with `DIN`=16'h1234 mid-slot 1:
  - `PEND`=1 next cycle.
  - `D` stays 0 until the frame boundary.
  - Then `D`=4,3,2,1 in slots 0..3 and `PEND`=0.
- `LD` with 16'hAAAA, then `LD` with 16'h5678 before the boundary: the next frame shows 8,7,6,5; 16'hAAAA is never displayed.
- `LD` with 16'h00C0 exactly on a frame-boundary cycle while 16'h1111 is pending:
  - The next frame shows 1,1,1,1 with `PEND` still 1.
  - The frame after shows 0,C,0,0 with `PEND`=0.
- `RST` pulse in slot 2 while 16'hBEEF is displayed and pending data is present:
  - `SA`=1111, `D`=0, `PEND`=0 immediately.
  - After release, the scan restarts at slot 0 with zeros.
- With `LED7SEG_LZB_EN`, `DIN`=16'h0030:
  - Slots 0 and 1 are lit with `D`=0 and 3.
  - Slots 2 and 3 keep `SA`=1111 for all 8 cycles.
  - With `DIN`=0, only slot 0 is lit.
